// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty decodes and sticky error flags.
// Simultaneous read+write on an empty FIFO bypasses the input straight to out.
module sync_fifo #(
    parameter int unsigned LENGTH = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_cs,
    input  logic             wr_en,
    input  logic             rd_cs,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned CNT_W = $clog2(LENGTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LENGTH);

    logic [WIDTH-1:0] mem [LENGTH];

    logic [PTR_W-1:0] wp_q, rp_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] out_q;
    logic             overflow_q, underflow_q;

    logic wr_req, rd_req;
    logic do_write, do_read, bypass;

    assign wr_req = wr_cs & wr_en;
    assign rd_req = rd_cs & rd_en;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A write alongside a read on a non-empty FIFO is always accepted, even when full.
    assign do_write = wr_req & (rd_req ? ~empty : ~full);
    assign do_read  = rd_req & ~empty;
    assign bypass   = wr_req & rd_req & empty;

    assign out       = out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Storage is not reset; its contents are never observable until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wp_q] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wp_q <= (wp_q == PTR_LAST) ? '0 : wp_q + PTR_W'(1);
            end
            if (do_read) begin
                rp_q  <= (rp_q == PTR_LAST) ? '0 : rp_q + PTR_W'(1);
                out_q <= mem[rp_q];
            end else if (bypass) begin
                out_q <= in;
            end
            if (do_write && !do_read) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_read && !do_write) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (wr_req && !rd_req && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned LENGTH = 4;
    localparam int unsigned WIDTH  = 8;

    logic             clk;
    logic             rst;
    logic             wr_cs, wr_en, rd_cs, rd_en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             full, empty, overflow, underflow;

    sync_fifo #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_cs     (wr_cs),
        .wr_en     (wr_en),
        .rd_cs     (rd_cs),
        .rd_en     (rd_en),
        .in        (in),
        .out       (out),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_out;
    logic             m_ovf, m_udf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"},       32'(out),       32'(m_out));
        check({tag, ".full"},      32'(full),      32'(q.size() == LENGTH));
        check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Apply one clock of stimulus, advance the model, then compare.
    task automatic step(input string tag, input logic wcs, input logic wen,
                        input logic rcs, input logic ren, input logic [WIDTH-1:0] din);
        logic wr, rd;
        wr_cs = wcs; wr_en = wen; rd_cs = rcs; rd_en = ren; in = din;
        @(posedge clk);
        #1;
        wr = wcs & wen;
        rd = rcs & ren;
        if (rd && q.size() == 0) begin
            m_udf = 1'b1;
            if (wr) m_out = din;
        end else if (rd) begin
            m_out = q.pop_front();
            if (wr) q.push_back(din);
        end else if (wr) begin
            if (q.size() == LENGTH) m_ovf = 1'b1;
            else q.push_back(din);
        end
        wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        step("push", 1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic pop(input logic [WIDTH-1:0] exp);
        step("pop", 1'b0, 1'b0, 1'b1, 1'b1, '0);
        check("pop.value", 32'(out), 32'(exp));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pat_a [4];
        logic [7:0] pat_b [4];
        logic [7:0] pat_c [8];
        pat_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        pat_b = '{8'h66, 8'h77, 8'h88, 8'h99};
        pat_c = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};

        rst = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; in = '0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill and drain
        foreach (pat_a[i]) push(pat_a[i]);
        check("fill.full", 32'(full), 32'd1);
        foreach (pat_a[i]) pop(pat_a[i]);
        check("drain.empty", 32'(empty), 32'd1);
        check("drain.flags", 32'({overflow, underflow}), 32'd0);

        // Bypass on empty
        foreach (pat_b[i]) begin
            step("bypass", 1'b1, 1'b1, 1'b1, 1'b1, pat_b[i]);
            check("bypass.value", 32'(out), 32'(pat_b[i]));
        end
        check("bypass.udf", 32'(underflow), 32'd1);

        // Overflow
        async_reset("rst1");
        foreach (pat_c[i]) push(pat_c[i]);
        check("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop(pat_c[i]);

        // Wrap-around
        async_reset("rst2");
        push(8'h99); push(8'hAA); push(8'hBB);
        pop(8'h99); pop(8'hAA);
        push(8'hCC); push(8'hDD); push(8'hEE);
        pop(8'hBB); pop(8'hCC); pop(8'hDD); pop(8'hEE);
        check("wrap.empty", 32'(empty), 32'd1);

        // Simultaneous read+write while full
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        step("rw_full", 1'b1, 1'b1, 1'b1, 1'b1, 8'h05);
        check("rw_full.out", 32'(out), 32'h01);

        // Gating
        step("gate_w", 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0);
        step("gate_w2", 1'b1, 1'b0, 1'b0, 1'b0, 8'hF1);
        step("gate_r", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step("gate_r2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Async reset mid-operation with 2 entries and overflow set
        async_reset("rst3");
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
        pop(8'hA1); pop(8'hA2);
        check("pre_rst.ovf", 32'(overflow), 32'd1);
        async_reset("rst_mid");
        push(8'h5A);
        pop(8'h5A);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 8'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
